// File: rtl/key_debounce16.sv
// Sixteen-key synchroniser/debouncer feeding the 16-to-4 priority encoder, with a press strobe and key index.
// Define KEY_HOLD_LATCH_EN to make the byte outputs hold only the most recent press instead of live levels.
module key_debounce16 #(
    parameter int CLK_DIV    = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] key_raw_N,
    output logic [7:0]  in_15_8,
    output logic [7:0]  in_7_0,
    output logic        press_pulse,
    output logic [3:0]  press_idx
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [3:0]      CNT_LAST   = 4'(STABLE_CNT - 1);

    logic [15:0]       r_sync1;
    logic [15:0]       r_sync2;
    logic [PW-1:0]     r_presc;
    logic [15:0]       r_stable;
    logic [15:0][3:0]  r_cnt;
    logic [15:0]       r_out;
    logic              r_press_pulse;
    logic [3:0]        r_press_idx;

    logic              w_tick;
    logic [15:0]       w_stable_nxt;
    logic [15:0][3:0]  w_cnt_nxt;
    logic [15:0]       w_newp;
    logic [3:0]        w_idx;
    logic [15:0]       w_out_nxt;

    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt;
        if (w_tick) begin
            for (int k = 0; k < 16; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    w_cnt_nxt[k] = 4'd0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    w_stable_nxt[k] = r_sync2[k];
                    w_cnt_nxt[k]    = 4'd0;
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + 4'd1;
                end
            end
        end
    end

    // Later iterations overwrite earlier ones, so the highest pressed key wins like the encoder.
    always_comb begin
        w_newp = r_stable & ~w_stable_nxt;
        w_idx  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (w_newp[k]) begin
                w_idx = 4'(k);
            end
        end
    end

`ifdef KEY_HOLD_LATCH_EN
    always_comb begin
        w_out_nxt = r_out;
        if (|w_newp) begin
            w_out_nxt = ~(16'd1 << w_idx);
        end
    end
`else
    always_comb begin
        w_out_nxt = w_stable_nxt;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_presc       <= '0;
            r_stable      <= '1;
            r_cnt         <= '0;
            r_out         <= '1;
            r_press_pulse <= 1'b0;
            r_press_idx   <= 4'd0;
        end else begin
            r_sync1  <= key_raw_N;
            r_sync2  <= r_sync1;
            r_presc  <= w_tick ? '0 : r_presc + PW'(1);
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_press_pulse <= |w_newp;
            if (|w_newp) begin
                r_press_idx <= w_idx;
            end
        end
    end

    assign in_15_8     = r_out[15:8];
    assign in_7_0      = r_out[7:0];
    assign press_pulse = r_press_pulse;
    assign press_idx   = r_press_idx;

endmodule
